// File: rtl/rv32i_fetch_queue_unit.sv
// RV32I fetch unit: PC sequencer, synchronous-read IMEM with loader port,
// and a decoupling {pc, inst} queue presented to ID over valid/ready.
module rv32i_fetch_queue_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          FQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_inst_o,
    output logic        misalign_o,
    input  logic        s_axi_wr_en_i,
    input  logic [31:0] s_axi_addr_i,
    input  logic [31:0] s_axi_data_i,
    output logic [31:0] s_axi_id_pc_o,
    output logic [31:0] s_axi_id_inst_o
);

    localparam int          AW    = $clog2(IMEM_DEPTH);
    localparam int          QW    = $clog2(FQ_DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [32:0] LIMIT = 33'(IMEM_DEPTH) << 2;

    logic [31:0]   mem [IMEM_DEPTH];
    logic [31:0]   rdata_q;
    logic [31:0]   qpc [FQ_DEPTH];
    logic [31:0]   qinst [FQ_DEPTH];

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q, tag_d;
    logic          inflight_q, inflight_d;
    logic          mis_q, mis_d;
    logic [QW-1:0] wp_q, wp_d;
    logic [QW-1:0] rp_q, rp_d;
    logic [QW:0]   cnt_q, cnt_d;

    logic [QW+1:0] occ;
    logic [AW-1:0] raddr;
    logic [AW-1:0] waddr;
    logic          wr_ok;
    logic          head_v;
    logic          issue;
    logic          push;
    logic          pop;

    assign raddr  = pc_q[AW+1:2];
    assign waddr  = s_axi_addr_i[AW+1:2];
    assign wr_ok  = s_axi_wr_en_i && ({1'b0, s_axi_addr_i} < LIMIT);
    assign head_v = (cnt_q != '0);
    assign occ    = {1'b0, cnt_q} + {{(QW+1){1'b0}}, inflight_q};
    assign issue  = !stall_i && !redirect_i && !mis_q
                    && (occ < (QW+2)'(FQ_DEPTH));
    assign push   = inflight_q && !redirect_i;
    assign pop    = head_v && id_ready_i && !redirect_i;

    // IMEM: loader write plus read-first word read every cycle.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= s_axi_data_i;
        end
        rdata_q <= mem[raddr];
    end

    // Queue storage: returning read is written with its PC tag.
    always_ff @(posedge clk) begin
        if (push) begin
            qpc[wp_q]   <= tag_q;
            qinst[wp_q] <= rdata_q;
        end
    end

    // Next state: redirect flushes everything and reloads the PC.
    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        mis_d      = mis_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        cnt_d      = cnt_q;
        if (redirect_i) begin
            pc_d  = redirect_pc_i;
            mis_d = |redirect_pc_i[1:0];
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (issue) begin
                pc_d  = pc_q + 32'd4;
                tag_d = pc_q;
            end
            if (push) begin
                wp_d = wp_q + QW'(1);
            end
            if (pop) begin
                rp_d = rp_q + QW'(1);
            end
            cnt_d = cnt_q + (QW+1)'(push) - (QW+1)'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            mis_q      <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            mis_q      <= mis_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign id_valid_o      = head_v;
    assign id_pc_o         = head_v ? qpc[rp_q] : '0;
    assign id_pc4_o        = head_v ? (qpc[rp_q] + 32'd4) : '0;
    assign id_inst_o       = head_v ? qinst[rp_q] : NOP;
    assign misalign_o      = mis_q;
    assign s_axi_id_pc_o   = pc_q;
    assign s_axi_id_inst_o = rdata_q;

endmodule

// File: tb/tb_rv32i_fetch_queue_unit.sv
// Bench for rv32i_fetch_queue_unit: directed vectors and sequences,
// then random traffic against a queue-based reference model.
module tb_rv32i_fetch_queue_unit;

    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam int          FQD   = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        vld;
    logic [31:0] opc;
    logic [31:0] opc4;
    logic [31:0] oinst;
    logic        mis;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] dpc;
    logic [31:0] dinst;

    rv32i_fetch_queue_unit #(
        .RESET_PC  (32'h0),
        .IMEM_DEPTH(DEPTH),
        .FQ_DEPTH  (FQD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_i        (stall),
        .redirect_i     (redir),
        .redirect_pc_i  (rpc),
        .id_ready_i     (rdy),
        .id_valid_o     (vld),
        .id_pc_o        (opc),
        .id_pc4_o       (opc4),
        .id_inst_o      (oinst),
        .misalign_o     (mis),
        .s_axi_wr_en_i  (we),
        .s_axi_addr_i   (wa),
        .s_axi_data_i   (wd),
        .s_axi_id_pc_o  (dpc),
        .s_axi_id_inst_o(dinst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        bit          s;
        bit          r;
        logic [31:0] rpc;
        bit          rdy;
        bit          ev;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    ent_t        mq[$];
    logic [31:0] mmem [DEPTH];
    logic [31:0] m_pc;
    logic [31:0] m_tag;
    logic [31:0] m_fdata;
    logic [31:0] m_rd;
    bit          m_infl;
    bit          m_mis;
    bit          m_rdk;

    int nvec;
    int nerr;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_infl = 1'b0;
        m_mis  = 1'b0;
        m_rdk  = 1'b0;
    endtask

    task automatic model_update(input bit s, input bit r,
                                input logic [31:0] t, input bit rd,
                                input bit w, input logic [31:0] a,
                                input logic [31:0] d);
        logic [31:0] rnew;
        int          occ;
        ent_t        e;
        rnew = mmem[m_pc[AW+1:2]];
        occ  = mq.size() + int'(m_infl);
        if (r) begin
            mq.delete();
            m_infl = 1'b0;
            m_pc   = t;
            m_mis  = (t[1:0] != 2'b00);
        end else begin
            if (mq.size() > 0 && rd) void'(mq.pop_front());
            if (m_infl) begin
                e.pc   = m_tag;
                e.inst = m_fdata;
                mq.push_back(e);
            end
            if (!s && !m_mis && occ < FQD) begin
                m_infl  = 1'b1;
                m_tag   = m_pc;
                m_fdata = rnew;
                m_pc    = m_pc + 32'd4;
            end else begin
                m_infl = 1'b0;
            end
        end
        if (w && a < 32'(DEPTH * 4)) mmem[a[AW+1:2]] = d;
        m_rd  = rnew;
        m_rdk = 1'b1;
    endtask

    task automatic compare_model();
        bit hv;
        hv = (mq.size() > 0);
        chk("m_valid", 32'(vld), 32'(hv));
        chk("m_pc", opc, hv ? mq[0].pc : 32'h0);
        chk("m_pc4", opc4, hv ? mq[0].pc + 32'd4 : 32'h0);
        chk("m_inst", oinst, hv ? mq[0].inst : NOP);
        chk("m_mis", 32'(mis), 32'(m_mis));
        chk("m_fpc", dpc, m_pc);
        if (m_rdk) chk("m_rdata", dinst, m_rd);
    endtask

    task automatic step(input bit s, input bit r, input logic [31:0] t,
                        input bit rd, input bit w = 1'b0,
                        input logic [31:0] a = 32'h0,
                        input logic [31:0] d = 32'h0);
        stall = s;
        redir = r;
        rpc   = t;
        rdy   = rd;
        we    = w;
        wa    = a;
        wd    = d;
        #1;
        compare_model();
        @(posedge clk);
        model_update(s, r, t, rd, w, a, d);
        @(negedge clk);
    endtask

    task automatic reset_checks();
        chk("rst_valid", 32'(vld), 32'h0);
        chk("rst_pc", opc, 32'h0);
        chk("rst_pc4", opc4, 32'h0);
        chk("rst_inst", oinst, NOP);
        chk("rst_mis", 32'(mis), 32'h0);
        chk("rst_fpc", dpc, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        rdy   = 1'b0;
        we    = 1'b0;
        @(negedge clk);
        reset_checks();
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t        tv [10];
    logic [31:0] nxt;
    logic [31:0] spc;
    int          pops;

    initial begin
        nvec  = 0;
        nerr  = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redir = 1'b0;
        rpc   = 32'h0;
        rdy   = 1'b0;
        we    = 1'b0;
        wa    = 32'h0;
        wd    = 32'h0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            we      = 1'b1;
            wa      = 32'(i * 4);
            wd      = 32'hA000_0000 + 32'(i);
            mmem[i] = wd;
        end
        @(negedge clk);
        we = 1'b0;
        reset_checks();
        rst_n = 1'b1;
        model_reset();

        tv[0] = '{0, 0, 32'h0,  1, 0, 32'h0,  NOP};
        tv[1] = '{0, 0, 32'h0,  1, 0, 32'h0,  NOP};
        tv[2] = '{0, 0, 32'h0,  1, 1, 32'h0,  32'hA000_0000};
        tv[3] = '{0, 0, 32'h0,  1, 1, 32'h4,  32'hA000_0001};
        tv[4] = '{0, 0, 32'h0,  1, 1, 32'h8,  32'hA000_0002};
        tv[5] = '{0, 0, 32'h0,  1, 1, 32'hC,  32'hA000_0003};
        tv[6] = '{0, 1, 32'h20, 1, 1, 32'h10, 32'hA000_0004};
        tv[7] = '{0, 0, 32'h0,  1, 0, 32'h0,  NOP};
        tv[8] = '{0, 0, 32'h0,  1, 0, 32'h0,  NOP};
        tv[9] = '{0, 0, 32'h0,  1, 1, 32'h20, 32'hA000_0008};
        for (int i = 0; i < 10; i++) begin
            chk("t1_valid", 32'(vld), 32'(tv[i].ev));
            if (tv[i].ev) begin
                chk("t1_pc", opc, tv[i].epc);
                chk("t1_pc4", opc4, tv[i].epc + 32'd4);
            end
            chk("t1_inst", oinst, tv[i].einst);
            step(tv[i].s, tv[i].r, tv[i].rpc, tv[i].rdy);
        end

        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 32'h0, 0);
        chk("t2_fpc_hold", dpc, 32'(4 * FQD));
        for (int k = 0; k < 5; k++) begin
            chk("t2_valid", 32'(vld), 32'h1);
            chk("t2_order", opc, 32'(4 * k));
            step(0, 0, 32'h0, 1);
        end

        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0);
        step(0, 1, 32'h40, 0);
        chk("t3_flushed", 32'(vld), 32'h0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        chk("t3_valid", 32'(vld), 32'h1);
        chk("t3_pc", opc, 32'h40);
        chk("t3_inst", oinst, 32'hA000_0010);

        step(0, 1, 32'h42, 1);
        chk("t4_mis_set", 32'(mis), 32'h1);
        for (int i = 0; i < 20; i++) begin
            chk("t4_novalid", 32'(vld), 32'h0);
            step(0, 0, 32'h0, 1);
        end
        chk("t4_fpc", dpc, 32'h42);
        step(0, 1, 32'h8, 1);
        chk("t4_mis_clr", 32'(mis), 32'h0);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        chk("t4_valid", 32'(vld), 32'h1);
        chk("t4_pc", opc, 32'h8);
        chk("t4_inst", oinst, 32'hA000_0002);

        for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 1);
        nxt  = opc;
        spc  = dpc;
        pops = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) chk("t5_pc_held", dpc, spc);
            if (vld) begin
                chk("t5_seq", opc, nxt);
                nxt = nxt + 32'd4;
                if (i < 5) pops++;
            end
            step(i < 5, 0, 32'h0, 1);
        end
        chk("t5_stall_pops", 32'(pops), 32'h2);

        step(0, 1, 32'h10, 1);
        step(0, 0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        step(0, 0, 32'h0, 1);
        chk("t6_old_pc", opc, 32'h10);
        chk("t6_old_inst", oinst, 32'hA000_0004);
        step(0, 1, 32'h10, 1);
        step(0, 0, 32'h0, 1);
        step(0, 0, 32'h0, 1);
        chk("t6_new_inst", oinst, 32'hDEAD_BEEF);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            case ($urandom_range(0, 3))
                0:       t = {21'h0, 9'($urandom_range(0, 511)), 2'b00};
                1:       t = $urandom;
                2:       t = 32'hFFFF_FFF8;
                default: t = 32'($urandom_range(0, 255)) << 2;
            endcase
            step($urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 4, t,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 10,
                 32'($urandom_range(0, 511)), $urandom);
        end

        step(0, 1, 32'h0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(vld), 32'h0);
        chk("arst_inst", oinst, NOP);
        chk("arst_fpc", dpc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 99) < 15, 1'b0, 32'h0,
                 $urandom_range(0, 99) < 60);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
